acct_scan_reader: RTL and testbench

Read-side companion to the ATM account register file. On a start pulse it walks every account register in index order and fetches each 32-bit binary balance through the register file's combinational read port. It converts each balance to 8-digit packed BCD with an iterative shift-add-3 (double-dabble) engine, then presents the result to the seven-segment display path with a valid flag. Each account is held for a programmable number of slow-clock ticks before the block advances.

---
 rtl/acct_scan_reader.sv | 129 ++++++++++++
 tb/tb_acct_scan_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acct_scan_reader.sv
// acct_scan_reader: scans every account register, converts each balance to packed BCD and shows it for a tick-based dwell.
//   Ports: clk/rst (async active-high) | start, tick in | rd_sel_o out, rd_data_i in (combinational register file read)
//          bcd_o, acct_o, valid_o, ovf_o, busy_o, done_o display/status outputs
//   Optional: `define ACCT_SCAN_SKIP_ZERO_EN to skip accounts whose balance is zero.
module acct_scan_reader #(
    parameter int NUM_ACCTS   = 16,
    parameter int DWELL_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    output logic [3:0]  rd_sel_o,
    input  logic [31:0] rd_data_i,
    output logic [31:0] bcd_o,
    output logic [3:0]  acct_o,
    output logic        valid_o,
    output logic        ovf_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam logic [3:0] LAST = 4'(NUM_ACCTS - 1);
    localparam logic [DW-1:0] DLAST = DW'(DWELL_TICKS - 1);
    localparam logic [31:0] MAX_BAL = 32'd99_999_999;
    typedef enum logic [1:0] {IDLE, FETCH, CONV, SHOW} state_t;
    state_t state_q, state_d;
    logic [3:0] idx_q, idx_d, acct_q, acct_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [4:0] cnt_q, cnt_d;
    logic [31:0] bin_q, bin_d, acc_q, acc_d, bcd_q, bcd_d, adj;
    logic ovf_q, ovf_d, done_q, done_d;
    // Double-dabble correction: any digit >= 5 would overflow past 9 when doubled.
    always_comb begin
        for (int i = 0; i < 8; i++)
            adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acct_d  = acct_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                idx_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                bin_d  = rd_data_i;
                acct_d = idx_q;
                if (rd_data_i > MAX_BAL) begin
                    ovf_d   = 1'b1;
                    bcd_d   = 32'h9999_9999;
                    state_d = SHOW;
                end
`ifdef ACCT_SCAN_SKIP_ZERO_EN
                else if (rd_data_i == '0) begin
                    done_d  = idx_q == LAST;
                    idx_d   = idx_q == LAST ? idx_q : idx_q + 4'd1;
                    state_d = idx_q == LAST ? IDLE : FETCH;
                end
`endif
                else begin
                    ovf_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {acc_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    bcd_d   = {adj[30:0], bin_q[31]};
                    state_d = SHOW;
                end
            end
            SHOW: if (tick) begin
                if (dwell_q == DLAST) begin
                    dwell_d = '0;
                    done_d  = idx_q == LAST;
                    idx_d   = idx_q == LAST ? idx_q : idx_q + 4'd1;
                    state_d = idx_q == LAST ? IDLE : FETCH;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acct_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acct_q  <= acct_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end
    assign rd_sel_o = idx_q;
    assign bcd_o    = bcd_q;
    assign acct_o   = acct_q;
    assign ovf_o    = ovf_q;
    assign done_o   = done_q;
    assign valid_o  = state_q == SHOW;
    assign busy_o   = state_q != IDLE;
endmodule

// File: tb/tb_acct_scan_reader.sv
// tb_acct_scan_reader: randomized self-checking bench for acct_scan_reader against a decimal-arithmetic reference.
module tb_acct_scan_reader;
    logic clk = 1'b0;
    logic rst, start, tick;
    logic [3:0] rd_sel_o, acct_o;
    logic [31:0] rd_data_i, bcd_o;
    logic valid_o, ovf_o, busy_o, done_o;
    logic [31:0] mem [16];
    int checks = 0;
    int failures = 0;
    logic [31:0] last_bcd;
    logic [3:0] last_acct;
    logic last_ovf;
`ifdef ACCT_SCAN_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    always #5 clk = ~clk;
    assign rd_data_i = mem[rd_sel_o];
    acct_scan_reader dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick),
        .rd_sel_o(rd_sel_o), .rd_data_i(rd_data_i),
        .bcd_o(bcd_o), .acct_o(acct_o), .valid_o(valid_o),
        .ovf_o(ovf_o), .busy_o(busy_o), .done_o(done_o)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        longint unsigned x;
        if (v > 32'd99_999_999) return 32'h9999_9999;
        x = v;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction
    task automatic run_scan(input bit rnd);
        int lat, n, fe, gaps;
        logic [31:0] v, eb;
        bit eo;
        lat = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = mem[i];
            if (SKIP && v == 0) begin
                lat++;
                continue;
            end
            eo = v > 32'd99_999_999;
            eb = to_bcd(v);
            fe = lat + 1;
            lat += eo ? 1 : 33;
            n = 0;
            while (!valid_o && n < 200) begin
                if (rnd) begin
                    tick = 1'($urandom);
                    start = 1'($urandom);
                end
                step();
                n++;
                if (rnd && n == fe) mem[i] = $urandom;
            end
            tick = 1'b0;
            start = 1'b0;
            checks++;
            if (n !== lat) begin
                failures++;
                $display("FAIL latency acct %0d: got %0d cycles want %0d", i, n, lat);
            end
            checks++;
            if (acct_o !== 4'(i) || bcd_o !== eb || ovf_o !== eo) begin
                failures++;
                $display("FAIL value acct %0d: got acct=%0d bcd=%h ovf=%b want acct=%0d bcd=%h ovf=%b",
                         i, acct_o, bcd_o, ovf_o, i, eb, eo);
            end
            lat = 0;
            for (int t = 0; t < 4; t++) begin
                gaps = rnd ? $urandom_range(0, 2) : 0;
                repeat (gaps) begin
                    start = rnd ? 1'($urandom) : 1'b0;
                    step();
                    start = 1'b0;
                    checks++;
                    if (valid_o !== 1'b1 || bcd_o !== eb || acct_o !== 4'(i)) begin
                        failures++;
                        $display("FAIL hold acct %0d: got valid=%b bcd=%h want valid=1 bcd=%h", i, valid_o, bcd_o, eb);
                    end
                end
                tick = 1'b1;
                step();
                tick = 1'b0;
                checks++;
                if (valid_o !== (t < 3)) begin
                    failures++;
                    $display("FAIL dwell acct %0d tick %0d: got valid=%b want %b", i, t + 1, valid_o, t < 3);
                end
            end
            last_bcd = eb;
            last_acct = 4'(i);
            last_ovf = eo;
        end
        repeat (lat) step();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL done pulse: got done=%b busy=%b valid=%b want 1 0 0", done_o, busy_o, valid_o);
        end
        step();
        checks++;
        if (done_o !== 1'b0 || bcd_o !== last_bcd || acct_o !== last_acct || ovf_o !== last_ovf) begin
            failures++;
            $display("FAIL after done: got done=%b bcd=%h acct=%0d ovf=%b want 0 %h %0d %b",
                     done_o, bcd_o, acct_o, ovf_o, last_bcd, last_acct, last_ovf);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        tick = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) step();
        checks++;
        if ({bcd_o, acct_o, rd_sel_o, valid_o, ovf_o, busy_o, done_o} !== '0) begin
            failures++;
            $display("FAIL reset: got bcd=%h acct=%0d sel=%0d valid=%b ovf=%b busy=%b done=%b want all 0",
                     bcd_o, acct_o, rd_sel_o, valid_o, ovf_o, busy_o, done_o);
        end
        rst = 1'b0;
        step();
        last_bcd = '0;
        last_acct = '0;
        last_ovf = 1'b0;
    endtask
    task automatic test_boundaries();
        mem[0] = 32'd12_345_678;
        mem[1] = 32'hFFFF_FFFE;
        mem[2] = 32'd99_999_999;
        mem[3] = 32'd100_000_000;
        mem[4] = 32'd0;
        mem[5] = 32'd9;
        for (int i = 6; i < 16; i++) mem[i] = $urandom_range(0, 99_999_999);
        run_scan(1'b0);
    endtask
    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 16; i++) mem[i] = $urandom_range(1, 99_999_999);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(acct_o == 4'd3 && busy_o && !valid_o) && n < 2000) begin
            tick = valid_o;
            step();
            n++;
        end
        tick = 1'b0;
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL reach acct3: got %0d cycles want < 2000", n);
        end
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bcd_o, acct_o, rd_sel_o, valid_o, ovf_o, busy_o, done_o} !== '0) begin
            failures++;
            $display("FAIL async reset: got bcd=%h acct=%0d sel=%0d valid=%b busy=%b done=%b want all 0",
                     bcd_o, acct_o, rd_sel_o, valid_o, busy_o, done_o);
        end
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL post reset: got done=%b busy=%b want 0 0", done_o, busy_o);
            end
        end
        last_bcd = '0;
        last_acct = '0;
        last_ovf = 1'b0;
        run_scan(1'b0);
    endtask
    task automatic test_random();
        repeat (2) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 5))
                    0: mem[i] = $urandom;
                    1: mem[i] = '0;
                    default: mem[i] = $urandom_range(0, 99_999_999);
                endcase
            end
            run_scan(1'b1);
        end
    endtask
    task automatic test_zero_scan();
        for (int i = 0; i < 15; i++) mem[i] = '0;
        mem[15] = 32'd7;
        run_scan(1'b0);
        for (int i = 0; i < 16; i++) mem[i] = '0;
        run_scan(1'b1);
    endtask
    initial begin
        test_reset();
        test_boundaries();
        test_reset_mid();
        test_random();
        test_zero_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
